// File: rtl/mult_pkg.sv
// Shared types and helpers for the multi-cycle multiplier (and divider cleanup logic).
package mult_pkg;

    localparam int MULT_W     = 32;
    localparam int MULT_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mult_state_t;

    // Two's-complement magnitude; 0x8000_0000 maps to itself as an unsigned value.
    function automatic logic [31:0] abs_val(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multiplier.sv
// Sign-magnitude shift-add multiplier for mult/multu: 32 RUN iterations, then a FIX
// cycle that applies the sign and writes hi/lo. Fixed 34-cycle start-to-done latency.
module multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    mult_state_t        state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mag_a;
    logic [2*WIDTH-1:0] prod;
    logic               neg;

    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     sum;
    logic               last_iter;

    always_comb begin
        in_mag_a  = (is_signed && multiplicand[WIDTH-1])  ? (~multiplicand + ONE_W)  : multiplicand;
        in_mag_b  = (is_signed && multiplier_in[WIDTH-1]) ? (~multiplier_in + ONE_W) : multiplier_in;
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag_a : '0)};
        last_iter = (count == CW'(ITERS - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            mag_a <= '0;
            prod  <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= in_mag_a;
                        prod  <= {{WIDTH{1'b0}}, in_mag_b};
                        neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier_in[WIDTH-1]);
                        count <= '0;
                    end
                end
                RUN: begin
                    // Carry out of the add enters the MSB as the register shifts right.
                    prod  <= {sum, prod[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                FIX: begin
                    {hi, lo} <= neg ? (~prod + ONE_2W) : prod;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for multiplier: cycle-exact busy/done checks plus hi/lo results.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] multiplicand;
    logic [31:0] multiplier_in;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    multiplier #(.WIDTH(32), .ITERS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier_in(multiplier_in),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge: this cycle becomes cycle 0 of the operation.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start         = 1'b1;
        is_signed     = sgn;
        multiplicand  = a;
        multiplier_in = b;
    endtask

    // Walks cycles 1..34 after a launch, checking busy/done each cycle and hi/lo at done.
    // Returns at the negedge of cycle 34 with start low.
    task automatic track(input string tag, input logic [63:0] exp, input bit glitch);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            check($sformatf("%s busy c%0d", tag, c), {63'd0, busy}, {63'd0, (c <= 33)});
            check($sformatf("%s done c%0d", tag, c), {63'd0, done}, {63'd0, (c == 34)});
            if (c == 1) begin
                is_signed     = ~is_signed;
                multiplicand  = 32'h1234_5678;
                multiplier_in = 32'h0BAD_F00D;
            end
            start = glitch && (c == 5 || c == 20);
        end
        check({tag, " result"}, {hi, lo}, exp);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, " done cleared"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        is_signed     = 1'b0;
        multiplicand  = '0;
        multiplier_in = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        launch(1'b0, 32'd3, 32'd5);
        track("multu 3x5", 64'h0000_0000_0000_000F, 1'b0);
        idle_cycle("multu 3x5");

        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        track("multu max", 64'hFFFF_FFFE_0000_0001, 1'b0);
        idle_cycle("multu max");

        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        track("mult -1x-1", 64'h0000_0000_0000_0001, 1'b0);
        idle_cycle("mult -1x-1");

        launch(1'b1, 32'hFFFF_FFFF, 32'h0000_0007);
        track("mult -1x7", 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        idle_cycle("mult -1x7");

        launch(1'b1, 32'h8000_0000, 32'h8000_0000);
        track("mult min^2", 64'h4000_0000_0000_0000, 1'b0);
        idle_cycle("mult min^2");

        launch(1'b0, 32'h8000_0000, 32'h0000_0002);
        track("multu carry", 64'h0000_0001_0000_0000, 1'b0);
        idle_cycle("multu carry");

        // Zero product with differing signs, plus ignored start pulses mid-run.
        launch(1'b1, 32'h0000_0000, 32'h8000_0000);
        track("mult 0 glitch", 64'h0, 1'b1);
        idle_cycle("mult 0 glitch");

        // Reset abort at cycle 10 of a run.
        launch(1'b0, 32'd3, 32'd5);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy c11", {63'd0, busy}, 64'd0);
        check("abort done c11", {63'd0, done}, 64'd0);
        check("abort hilo c11", {hi, lo}, 64'd0);
        @(negedge clk);
        check("abort done c12", {63'd0, done}, 64'd0);
        check("abort busy c12", {63'd0, busy}, 64'd0);
        launch(1'b0, 32'd12, 32'd12);
        track("multu 12x12", 64'h0000_0000_0000_0090, 1'b0);
        idle_cycle("multu 12x12");

        // Back-to-back: second start in the done cycle.
        launch(1'b0, 32'd7, 32'd9);
        track("b2b first", 64'h0000_0000_0000_003F, 1'b0);
        launch(1'b1, 32'hFFFF_FFFE, 32'd3);
        track("b2b second", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        idle_cycle("b2b second");
        @(negedge clk);
        check("hold hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Multi-cycle shift-add multiplier. Companion to the combinational divider in the ALU datapath; serves MIPS mult/multu.
- Takes two 32-bit operands, runs a fixed 32-iteration sequence, and writes a 64-bit product into hi/lo.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while it runs.
- Signed operation is sign-magnitude: negative operands are converted to their magnitude, multiplied unsigned, and the product is negated if the operand signs differ.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- ITERS, WIDTH, number of shift-add iterations; fixed, not user-tuned.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- is_signed  input  1  1 = mult (two's complement), 0 = multu
- multiplicand  input  WIDTH  operand A
- multiplier_in  input  WIDTH  operand B
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  WIDTH  upper half of the product
- lo  output  WIDTH  lower half of the product

Behaviour:
- One clock (clk). Reset is synchronous and active-high: on any rising edge with reset=1, state goes to IDLE and busy=0, done=0, hi=0, lo=0, count=0. Reset overrides start and an in-flight operation; no done is produced for an aborted operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - On start=1, latch operands and go to RUN with count=0.
  - Latched values: mag_a = |A| and mag_b = |B| when is_signed and the MSB is set; otherwise the raw value.
  - Latch neg = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]).
  - Load the product register P[2W-1:0] = {W'0, mag_b}.
- RUN, one iteration per clock:
  - Compute sum[W:0] = P[2W-1:W] + (P[0] ? mag_a : 0), 33 bits with the carry kept.
  - P <= {sum, P[W-1:1]}, a logical right shift with the carry entering the MSB.
  - count++.
  - After the iteration where count==ITERS-1, go to FIX.
- FIX: {hi,lo} <= neg ? (~P + 1) : P; done <= 1; go to IDLE.
- done is registered and high for exactly one cycle, the first IDLE cycle after FIX; it is cleared in every other cycle.
- hi/lo hold their value until the next FIX or reset.
- busy is registered: 1 in RUN and FIX, 0 in IDLE.
- Latency: start high in cycle 0, busy high in cycles 1-33, done high and hi/lo valid in cycle 34. Latency is fixed and does not depend on the data (zero operands still take 34 cycles).
- A start with busy=1 is ignored and is not queued. start in the done cycle (IDLE) is accepted (back-to-back).
- Operands and is_signed are sampled only on the accepting edge; later changes to the inputs have no effect.
- Magnitude edge case: |0x8000_0000| = 0x8000_0000 as an unsigned magnitude; no overflow, because the product of two magnitudes ≤ 2^62 fits in 64 bits.
- Negating a zero product yields zero; the result is never -0.

Decomposition:
- Shared package mult_pkg:
  - localparam MULT_W = 32 and MULT_ITERS = 32.
  - typedef enum logic [1:0] {IDLE, RUN, FIX} mult_state_t.
  - Function abs_val(logic [31:0]) for two's-complement magnitude; also usable by divider cleanup.
- No sub-module. Datapath and FSM live in one module.

Test Plan:
- multu 3 × 5, start in cycle 0 -> busy cycles 1-33, done in cycle 34 only, hi=0x0000_0000, lo=0x0000_000F.
- multu 0xFFFF_FFFF × 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; mult on the same operands (-1×-1) -> hi=0, lo=1.
- mult 0xFFFF_FFFF × 0x0000_0007 (-1×7) -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF9; mult 0x8000_0000 × 0x8000_0000 -> hi=0x4000_0000, lo=0.
- mult 0 × 0x8000_0000 -> hi=lo=0 with done still in cycle 34. Pulse start with new operands in cycles 5 and 20 -> ignored, result matches the cycle-0 operands.
- Assert reset in cycle 10 of a run -> cycle 11: busy=0, done=0, hi=lo=0, no done pulse afterwards. start in cycle 12 (12×12 multu) -> done in cycle 46 with lo=0x90.
- Back-to-back: second start in cycle 34 (the done cycle) -> accepted, busy cycles 35-67, second done in cycle 68 only.
